half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder.sv | 73 +++++++
 tb/tb_half_adder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Half adder with combinational sum/carry, a one-cycle registered result path,
// and an optional saturating carry-event counter built only when HALF_ADDER_STATS_EN is defined.
module half_adder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             in_valid,
  output logic             S,
  output logic             C,
  output logic             S_q,
  output logic             C_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  assign S = A ^ B;
  assign C = A & B;

  logic sum_q, sum_d;
  logic cy_q,  cy_d;
  logic vld_q, vld_d;

  // Result registers hold across idle cycles; valid simply tracks in_valid.
  always_comb begin
    sum_d = sum_q;
    cy_d  = cy_q;
    vld_d = in_valid;
    if (in_valid) begin
      sum_d = S;
      cy_d  = C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 1'b0;
      cy_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cy_q  <= cy_d;
      vld_q <= vld_d;
    end
  end

  assign S_q       = sum_q;
  assign C_q       = cy_q;
  assign out_valid = vld_q;

`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Gating on in_valid first keeps unknown addends from touching the count.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (A & B) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign carry_cnt = cnt_q;
`else
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: vector tables, directed corner sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_half_adder;
  localparam int CNT_W = 4;
`ifdef HALF_ADDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, clk_en = 1'b0;
  logic rst = 1'b0, A = 1'b0, B = 1'b0, in_valid = 1'b0;
  logic S, C, S_q, C_q, out_valid;
  logic [CNT_W-1:0] carry_cnt;

  half_adder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .S(S), .C(C), .S_q(S_q), .C_q(C_q), .out_valid(out_valid),
    .carry_cnt(carry_cnt)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic a;
    logic b;
    logic ec;
    logic es;
  } vec_t;

  vec_t vecs[4];
  int total = 0, bad = 0;
  int m_s = 0, m_c = 0, m_v = 0, m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies one clock edge's worth of behaviour from the rules.
  task automatic model_edge(input int a, input int b, input int v, input int r);
    if (r != 0) begin
      m_s = 0; m_c = 0; m_v = 0; m_cnt = 0;
    end else begin
      m_v = v;
      if (v != 0) begin
        m_s = (a + b) % 2;
        m_c = (a + b) / 2;
        if (STATS && a == 1 && b == 1 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step(input logic a, input logic b, input logic v, input logic r);
    A = a; B = b; in_valid = v; rst = r;
    #1;
    chk("comb_sum_carry", {30'd0, C, S}, int'(a) + int'(b));
    model_edge(int'(a), int'(b), int'(v), int'(r));
    @(posedge clk);
    #1;
    chk("S_q", int'(S_q), m_s);
    chk("C_q", int'(C_q), m_c);
    chk("out_valid", int'(out_valid), m_v);
    chk("carry_cnt", int'(carry_cnt), m_cnt);
  endtask

  initial begin
    vecs[0] = '{a: 1'b0, b: 1'b0, ec: 1'b0, es: 1'b0};
    vecs[1] = '{a: 1'b0, b: 1'b1, ec: 1'b0, es: 1'b1};
    vecs[2] = '{a: 1'b1, b: 1'b0, ec: 1'b0, es: 1'b1};
    vecs[3] = '{a: 1'b1, b: 1'b1, ec: 1'b1, es: 1'b0};

    // Combinational truth table with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      A = vecs[i].a; B = vecs[i].b;
      #10;
      chk("tt_S", int'(S), int'(vecs[i].es));
      chk("tt_C", int'(C), int'(vecs[i].ec));
    end

    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // Two reset cycles, then one carry-generating operation.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_then_11_S_q", int'(S_q), 0);
    chk("rst_then_11_C_q", int'(C_q), 1);
    chk("rst_then_11_cnt", int'(carry_cnt), STATS ? 1 : 0);

    // Back-to-back stream of all codes, then idle: results hold, valid drops.
    for (int i = 0; i < 4; i++) begin
      step(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      chk("stream_S_q", int'(S_q), int'(vecs[i].es));
      chk("stream_C_q", int'(C_q), int'(vecs[i].ec));
      chk("stream_vld", int'(out_valid), 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_hold_S_q", int'(S_q), 0);
    chk("idle_hold_C_q", int'(C_q), 1);
    chk("idle_vld", int'(out_valid), 0);

    // Reset coincident with a valid 11 input discards it.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    A = 1'b1; B = 1'b1; in_valid = 1'b1; rst = 1'b1;
    #1;
    chk("rst_pri_S_before", int'(S), 0);
    chk("rst_pri_C_before", int'(C), 1);
    model_edge(1, 1, 1, 1);
    @(posedge clk);
    #1;
    chk("rst_pri_S", int'(S), 0);
    chk("rst_pri_C", int'(C), 1);
    chk("rst_pri_S_q", int'(S_q), 0);
    chk("rst_pri_C_q", int'(C_q), 0);
    chk("rst_pri_vld", int'(out_valid), 0);
    chk("rst_pri_cnt", int'(carry_cnt), 0);

    // Saturation: 20 accepted carries into a 4-bit counter.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_cnt", int'(carry_cnt), STATS ? 15 : 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_idle_cnt", int'(carry_cnt), STATS ? 15 : 0);

    // Randomized traffic with occasional resets.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
